// File: rtl/room_pkg.sv
// ---------------------------------------------------------------------------
// room_pkg
//   Shared definitions for the room access controller: the door FSM state
//   encoding and helpers that derive the counter widths from the
//   capacity and grant-window parameters.
// ---------------------------------------------------------------------------
package room_pkg;

  // Door FSM: IDLE keeps the door locked, GRANT holds it unlocked.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Width needed to hold the occupancy values 0..cap inclusive.
  function automatic int room_cw(input int cap);
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction

  // Width of the grant window down-counter, which holds 0..win-1.
  function automatic int win_w(input int win);
    return (win <= 1) ? 1 : $clog2(win);
  endfunction

endpackage : room_pkg

// File: rtl/room_access_ctrl_occ_counter.sv
// ---------------------------------------------------------------------------
// occ_counter
//   Saturating up/down occupancy counter. Holds at MAXV and at 0, never
//   wraps. An increment and a decrement in the same cycle cancel out.
//   FULL and EMPTY are registered from the next count, so they change in
//   the same cycle as the count itself.
//
// Ports
//   clk    in   clock, rising edge
//   clr    in   synchronous active-high reset (count -> 0)
//   inc    in   add one occupant
//   dec    in   remove one occupant
//   count  out  current occupancy (CW bits)
//   full   out  count == MAXV
//   empty  out  count == 0
// ---------------------------------------------------------------------------
module occ_counter
  import room_pkg::*;
#(
  parameter int MAXV = 15,
  parameter int CW   = room_cw(MAXV)  // derived, do not override
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] MAX_VAL = CW'(MAXV);

  logic [CW-1:0] count_d, count_q;
  logic          full_d,  full_q;
  logic          empty_d, empty_q;

  // NOTE: every signal assigned in always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != MAX_VAL)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == MAX_VAL);
    empty_d = (count_d == '0);
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule : occ_counter

// File: rtl/room_access_ctrl.sv
// ---------------------------------------------------------------------------
// room_access_ctrl
//   Room door / occupancy controller. Grants entry on request during
//   visiting hours while the room is not full, keeps the door unlocked for
//   at most GRANT_WIN cycles (one entry per grant), tracks occupancy, and
//   raises a sticky alarm whenever someone enters without a grant.
//
// Ports
//   clk    in   clock, rising edge
//   CLR    in   synchronous active-high reset, overrides everything
//   IN     in   entry sensor, one person per sampled high cycle
//   OUT    in   exit sensor, one person per sampled high cycle
//   ENT    in   entry request
//   T      in   visiting hours active
//   ACK    in   clears ALARM
//   OPEN   out  door unlocked
//   CLOSE  out  door locked (always ~OPEN)
//   DENY   out  one-cycle pulse, request refused
//   ALARM  out  sticky, entry without a grant
//   FULL   out  COUNT == CAP
//   EMPTY  out  COUNT == 0
//   COUNT  out  current occupancy
// ---------------------------------------------------------------------------
module room_access_ctrl
  import room_pkg::*;
#(
  parameter int CAP       = 15,
  parameter int CW        = room_cw(CAP),  // derived, do not override
  parameter int GRANT_WIN = 4
) (
  input  logic          clk,
  input  logic          CLR,
  input  logic          IN,
  input  logic          OUT,
  input  logic          ENT,
  input  logic          T,
  input  logic          ACK,
  output logic          OPEN,
  output logic          CLOSE,
  output logic          DENY,
  output logic          ALARM,
  output logic          FULL,
  output logic          EMPTY,
  output logic [CW-1:0] COUNT
);

  localparam int            WW       = win_w(GRANT_WIN);
  localparam logic [WW-1:0] WIN_LOAD = WW'(GRANT_WIN - 1);

  state_e        state_d, state_q;
  logic [WW-1:0] win_d,   win_q;
  logic          open_d,  open_q;
  logic          close_d, close_q;
  logic          deny_d,  deny_q;
  logic          alarm_d, alarm_q;
  logic          entry_ok;   // authorised entry this cycle
  logic          unauth;     // entry seen without a valid grant

  // -------------------------------------------------------------------------
  // Occupancy counter
  // -------------------------------------------------------------------------
  occ_counter #(
    .MAXV (CAP),
    .CW   (CW)
  ) u_occ (
    .clk   (clk),
    .clr   (CLR),
    .inc   (entry_ok),
    .dec   (OUT),
    .count (COUNT),
    .full  (FULL),
    .empty (EMPTY)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    deny_d   = 1'b0;
    entry_ok = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ENT) begin
          // FULL is registered from the same count the counter holds, so it
          // reflects COUNT >= CAP for the current cycle.
          if (T && !FULL) begin
            state_d = ST_GRANT;
            win_d   = WIN_LOAD;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        // Leaving hours closes the door at once; ENT here is ignored and
        // never restarts the window.
        if (!T) begin
          state_d = ST_IDLE;
        end else if (IN) begin
          entry_ok = 1'b1;
          state_d  = ST_IDLE;
        end else if (win_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any entry that is not the one granted entry is unauthorised,
    // including one that coincides with T dropping mid-grant.
    unauth  = IN && !((state_q == ST_GRANT) && T);
    alarm_d = unauth || (alarm_q && !ACK);

    open_d  = (state_d == ST_GRANT);
    close_d = !open_d;
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      open_q  <= 1'b0;
      close_q <= 1'b1;
      deny_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      open_q  <= open_d;
      close_q <= close_d;
      deny_q  <= deny_d;
      alarm_q <= alarm_d;
    end
  end

  assign OPEN  = open_q;
  assign CLOSE = close_q;
  assign DENY  = deny_q;
  assign ALARM = alarm_q;

endmodule : room_access_ctrl
